dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: the page-table walker normally wins, a starvation
// counter guarantees the LSU a slot, and a flushed LSU access is drained without an ack.
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,

    input  logic                  i_ptw_req,
    input  logic [ADDR_W-1:0]     i_ptw_addr,
    output logic                  o_ptw_ack,
    output logic [DATA_W-1:0]     o_ptw_rdata,

    input  logic                  i_lsu_req,
    input  logic                  i_lsu_we,
    input  logic [ADDR_W-1:0]     i_lsu_addr,
    input  logic [DATA_W-1:0]     i_lsu_wdata,
    input  logic [DATA_W/8-1:0]   i_lsu_be,
    output logic                  o_lsu_ack,
    output logic [DATA_W-1:0]     o_lsu_rdata,

    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic OWN_PTW = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic [CNT_W-1:0]  starveCnt_q,  starveCnt_d;
    logic              memReq_q,     memReq_d;
    logic              memWe_q,      memWe_d;
    logic [ADDR_W-1:0] memAddr_q,    memAddr_d;
    logic [DATA_W-1:0] memWdata_q,   memWdata_d;
    logic [BE_W-1:0]   memBe_q,      memBe_d;
    logic              ptwAck_q,     ptwAck_d;
    logic              lsuAck_q,     lsuAck_d;
    logic [DATA_W-1:0] ptwRdata_q,   ptwRdata_d;
    logic [DATA_W-1:0] lsuRdata_q,   lsuRdata_d;

    logic ackCycle;
    logic ptwEligible;
    logic lsuEligible;
    logic lsuStarved;
    logic grantLsu;
    logic grantPtw;

    // The cycle an ack is visible is a turnaround cycle: the acked requester is still
    // dropping its req, so no grant is made, which yields the 3-cycle transaction rhythm.
    assign ackCycle    = ptwAck_q | lsuAck_q;
    assign ptwEligible = i_ptw_req & ~ackCycle;
    assign lsuEligible = i_lsu_req & ~i_flush & ~ackCycle;
    assign lsuStarved  = (starveCnt_q == STARVE_LIM);
    assign grantLsu    = lsuEligible & (~ptwEligible | lsuStarved);
    assign grantPtw    = ptwEligible & ~grantLsu;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starveCnt_d = starveCnt_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        memBe_d     = memBe_q;
        ptwAck_d    = 1'b0;
        lsuAck_d    = 1'b0;
        ptwRdata_d  = ptwRdata_q;
        lsuRdata_d  = lsuRdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grantPtw) begin
                    state_d    = ST_BUSY;
                    owner_d    = OWN_PTW;
                    memReq_d   = 1'b1;
                    memWe_d    = 1'b0;
                    memAddr_d  = i_ptw_addr;
                    memWdata_d = '0;
                    memBe_d    = '1;
                    if (i_lsu_req && !lsuStarved) begin
                        starveCnt_d = starveCnt_q + CNT_W'(1);
                    end
                end else if (grantLsu) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWN_LSU;
                    memReq_d    = 1'b1;
                    memWe_d     = i_lsu_we;
                    memAddr_d   = i_lsu_addr;
                    memWdata_d  = i_lsu_wdata;
                    memBe_d     = i_lsu_be;
                    starveCnt_d = '0;
                end
            end

            ST_BUSY: begin
                if (i_mem_ack) begin
                    state_d  = ST_IDLE;
                    memReq_d = 1'b0;
                    if (owner_q == OWN_PTW) begin
                        ptwAck_d   = 1'b1;
                        ptwRdata_d = i_mem_rdata;
                    end else if (!i_flush) begin
                        lsuAck_d   = 1'b1;
                        lsuRdata_d = memWe_q ? '0 : i_mem_rdata;
                    end
                end else if (owner_q == OWN_LSU && i_flush) begin
                    state_d = ST_DRAIN;
                end
            end

            // The memory still owes a response for the killed LSU access; absorb it silently.
            ST_DRAIN: begin
                if (i_mem_ack) begin
                    state_d  = ST_IDLE;
                    memReq_d = 1'b0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_PTW;
            starveCnt_q <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memBe_q     <= '0;
            ptwAck_q    <= 1'b0;
            lsuAck_q    <= 1'b0;
            ptwRdata_q  <= '0;
            lsuRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starveCnt_q <= starveCnt_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memBe_q     <= memBe_d;
            ptwAck_q    <= ptwAck_d;
            lsuAck_q    <= lsuAck_d;
            ptwRdata_q  <= ptwRdata_d;
            lsuRdata_q  <= lsuRdata_d;
        end
    end

    assign o_mem_req   = memReq_q;
    assign o_mem_we    = memWe_q;
    assign o_mem_addr  = memAddr_q;
    assign o_mem_wdata = memWdata_q;
    assign o_mem_be    = memBe_q;
    assign o_ptw_ack   = ptwAck_q;
    assign o_ptw_rdata = ptwRdata_q;
    assign o_lsu_ack   = lsuAck_q;
    assign o_lsu_rdata = lsuRdata_q;

endmodule
